// File: rtl/ddio_in.sv
// DDR input capture: samples datain on both inclock edges, presents rise/fall pairs on two SDR buses.
// Latency: rising sample 1 edge to dataout_h; falling sample appears on dataout_l at the next rising edge.
// Backpressure: none; every edge samples unconditionally, and the consumer samples on posedge inclock.
module ddio_in #(
  parameter int WIDTH = 8
) (
  input  logic             inclock,
  input  logic             aclr_n,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout_h,
  output logic [WIDTH-1:0] dataout_l
);

  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;
  logic [WIDTH-1:0] l_d,    l_q;

  // Next-state: both capture banks take the pins directly; the low bank
  // re-times the falling sample into the rising-edge domain.
  always_comb begin
    rise_d = datain;
    fall_d = datain;
    l_d    = fall_q;
  end

  // Rising-edge banks: the new rising sample and the re-timed falling sample
  // update together, so the two outputs always form a coherent pair.
  always_ff @(posedge inclock or negedge aclr_n) begin
    if (!aclr_n) begin
      rise_q <= '0;
      l_q    <= '0;
    end else begin
      rise_q <= rise_d;
      l_q    <= l_d;
    end
  end

  // Falling-edge bank: holds the mid-cycle sample until the next rising edge.
  always_ff @(negedge inclock or negedge aclr_n) begin
    if (!aclr_n) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  // Outputs come straight from flops: no combinational path from datain.
  assign dataout_h = rise_q;
  assign dataout_l = l_q;

endmodule

// File: tb/tb_ddio_in.sv
// Testbench for ddio_in: scoreboard of expected {h,l} pairs per rising edge,
// plus directed checks for reset, lane independence and serial reconstruction.
// Stimulus changes 1 time unit after each edge; outputs are sampled 1 unit after posedge.
module tb_ddio_in;
  localparam int WIDTH = 8;

  logic             inclock = 1'b0;
  logic             aclr_n;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout_h;
  logic [WIDTH-1:0] dataout_l;

  int checks = 0;
  int errors = 0;

  logic [15:0]      exp_q[$];
  logic [WIDTH-1:0] model_fall;

  ddio_in #(.WIDTH(WIDTH)) dut (
    .inclock  (inclock),
    .aclr_n   (aclr_n),
    .datain   (datain),
    .dataout_h(dataout_h),
    .dataout_l(dataout_l)
  );

  always #5 inclock = ~inclock;

  // One clock: called in the low phase. Drives r for the rising edge, checks the
  // scoreboard after it, then drives f for the falling edge.
  task automatic drive_cycle(input logic [7:0] r, input logic [7:0] f,
                             output logic [7:0] oh, output logic [7:0] ol);
    logic [15:0] e;
    datain = r;
    exp_q.push_back({r, model_fall});
    @(posedge inclock); #1;
    oh = dataout_h;
    ol = dataout_l;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got h=%h l=%h", oh, ol);
    end else begin
      e = exp_q.pop_front();
      if ({oh, ol} !== e) begin
        errors++;
        $display("FAIL scoreboard got h=%h l=%h expected h=%h l=%h", oh, ol, e[15:8], e[7:0]);
      end
    end
    datain = f;
    @(negedge inclock); #1;
    model_fall = f;
  endtask

  task automatic test_reset();
    aclr_n     = 1'b0;
    datain     = 8'h00;
    model_fall = 8'h00;
    for (int i = 0; i < 8; i++) begin
      datain = i[0] ? 8'h00 : 8'hFF;
      @(inclock); #1;
      checks++;
      if (dataout_h !== 8'h00 || dataout_l !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold got h=%h l=%h expected h=00 l=00", dataout_h, dataout_l);
      end
    end
    @(negedge inclock); #1;
  endtask

  task automatic test_reset_release();
    logic [7:0] oh, ol;
    aclr_n = 1'b1;
    drive_cycle(8'h81, 8'h81, oh, ol);
    checks++;
    if (oh !== 8'h81 || ol !== 8'h00) begin
      errors++;
      $display("FAIL release_first got h=%h l=%h expected h=81 l=00", oh, ol);
    end
    drive_cycle(8'h81, 8'h81, oh, ol);
    checks++;
    if (ol !== 8'h81) begin
      errors++;
      $display("FAIL release_second got l=%h expected l=81", ol);
    end
  endtask

  task automatic test_basic();
    logic [7:0] oh, ol;
    drive_cycle(8'hA5, 8'h3C, oh, ol);
    checks++;
    if (oh !== 8'hA5) begin
      errors++;
      $display("FAIL basic_rise got h=%h expected h=a5", oh);
    end
    drive_cycle(8'h5E, 8'h00, oh, ol);
    checks++;
    if (ol !== 8'h3C || oh !== 8'h5E) begin
      errors++;
      $display("FAIL basic_pair got h=%h l=%h expected h=5e l=3c", oh, ol);
    end
  endtask

  task automatic test_alternating();
    logic [7:0] oh, ol;
    for (int i = 0; i < 4; i++) drive_cycle(8'hFF, 8'h00, oh, ol);
    checks++;
    if (oh !== 8'hFF || ol !== 8'h00) begin
      errors++;
      $display("FAIL alt_ff00 got h=%h l=%h expected h=ff l=00", oh, ol);
    end
    for (int i = 0; i < 4; i++) drive_cycle(8'h00, 8'hFF, oh, ol);
    checks++;
    if (oh !== 8'h00 || ol !== 8'hFF) begin
      errors++;
      $display("FAIL alt_00ff got h=%h l=%h expected h=00 l=ff", oh, ol);
    end
  endtask

  task automatic test_lanes();
    logic [7:0] oh, ol, bit_i;
    drive_cycle(8'h00, 8'h00, oh, ol);
    for (int i = 0; i < WIDTH; i++) begin
      bit_i = 8'h01 << i;
      drive_cycle(bit_i, 8'h00, oh, ol);
      checks++;
      if (oh !== bit_i) begin
        errors++;
        $display("FAIL lane%0d_rise got h=%h expected h=%h", i, oh, bit_i);
      end
      drive_cycle(8'h00, 8'h00, oh, ol);
      checks++;
      if (oh !== 8'h00 || ol !== 8'h00) begin
        errors++;
        $display("FAIL lane%0d_rise_clear got h=%h l=%h expected h=00 l=00", i, oh, ol);
      end
      drive_cycle(8'h00, bit_i, oh, ol);
      checks++;
      if (ol !== 8'h00) begin
        errors++;
        $display("FAIL lane%0d_fall_early got l=%h expected l=00", i, ol);
      end
      drive_cycle(8'h00, 8'h00, oh, ol);
      checks++;
      if (ol !== bit_i || oh !== 8'h00) begin
        errors++;
        $display("FAIL lane%0d_fall got h=%h l=%h expected h=00 l=%h", i, oh, ol, bit_i);
      end
    end
  endtask

  task automatic test_serial();
    logic [11:0] word;
    logic [11:0] rec;
    logic [7:0]  oh, ol, r, f;
    word = 12'hB2D;
    rec  = 12'h000;
    for (int c = 0; c < 7; c++) begin
      r = 8'h00;
      f = 8'h00;
      if (c < 6) begin
        r[0] = word[11 - 2*c];
        f[0] = word[10 - 2*c];
      end
      drive_cycle(r, f, oh, ol);
      if (c < 6) rec[11 - 2*c] = oh[0];
      if (c > 0) rec[12 - 2*c] = ol[0];
    end
    checks++;
    if (rec !== word) begin
      errors++;
      $display("FAIL serial_rebuild got %h expected %h", rec, word);
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] oh, ol;
    drive_cycle(8'h5A, 8'hC3, oh, ol);
    drive_cycle(8'h77, 8'h99, oh, ol);
    datain = 8'h11;
    @(posedge inclock); #3;
    checks++;
    if (dataout_h !== 8'h11 || dataout_l !== 8'h99) begin
      errors++;
      $display("FAIL mid_pre got h=%h l=%h expected h=11 l=99", dataout_h, dataout_l);
    end
    aclr_n = 1'b0;
    #1;
    checks++;
    if (dataout_h !== 8'h00 || dataout_l !== 8'h00) begin
      errors++;
      $display("FAIL mid_async got h=%h l=%h expected h=00 l=00", dataout_h, dataout_l);
    end
    datain = 8'hEE;
    @(posedge inclock); #1;
    checks++;
    if (dataout_h !== 8'h00 || dataout_l !== 8'h00) begin
      errors++;
      $display("FAIL mid_hold got h=%h l=%h expected h=00 l=00", dataout_h, dataout_l);
    end
    @(negedge inclock); #1;
    model_fall = 8'h00;
    aclr_n     = 1'b1;
    drive_cycle(8'h24, 8'h42, oh, ol);
    checks++;
    if (oh !== 8'h24 || ol !== 8'h00) begin
      errors++;
      $display("FAIL mid_residue got h=%h l=%h expected h=24 l=00", oh, ol);
    end
    drive_cycle(8'h00, 8'h00, oh, ol);
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_basic();
    test_alternating();
    test_lanes();
    test_serial();
    test_midstream_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
